alu_seq: RTL and testbench

ALU_SEQ -- requirements
Module: alu_seq

---
 rtl/alu_seq.sv | 197 +++++++++++++++++++
 tb/tb_alu_seq.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/alu_seq.sv
// Sequential ALU: single-cycle logic/arith ops plus iterative MUL and DIVU/REMU.
// Define ALU_SEQ_DIV_EN to build the divider; otherwise DIVU/REMU are illegal.
module alu_seq #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [4:0]       ALUop,
    input  logic [WIDTH-1:0] X,
    input  logic [WIDTH-1:0] Y,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] z,
    output logic             err
);

    localparam int SW = $clog2(WIDTH);
    localparam logic [SW-1:0] CNT_LAST = SW'(WIDTH - 1);

    localparam logic [4:0] OP_ADD  = 5'b00000;
    localparam logic [4:0] OP_SUB  = 5'b00001;
    localparam logic [4:0] OP_AND  = 5'b00010;
    localparam logic [4:0] OP_OR   = 5'b00011;
    localparam logic [4:0] OP_XOR  = 5'b00100;
    localparam logic [4:0] OP_NOT  = 5'b00101;
    localparam logic [4:0] OP_SHL  = 5'b00110;
    localparam logic [4:0] OP_SHR  = 5'b00111;
    localparam logic [4:0] OP_SRA  = 5'b01000;
    localparam logic [4:0] OP_SLT  = 5'b01001;
    localparam logic [4:0] OP_MUL  = 5'b01010;
`ifdef ALU_SEQ_DIV_EN
    localparam logic [4:0] OP_DIVU = 5'b01011;
    localparam logic [4:0] OP_REMU = 5'b01100;
`endif

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t           state_q, state_d;
    logic [4:0]       op_q, op_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [SW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] z_q, z_d;
    logic             err_q, err_d;

    logic [SW-1:0]    shamt;
    logic [WIDTH-1:0] fast_z;
    logic             fast_err;
    logic             is_iter;
    logic [WIDTH-1:0] mul_acc;

    assign shamt = Y[SW-1:0];

    always_comb begin
        fast_z   = '0;
        fast_err = 1'b0;
        is_iter  = 1'b0;
        case (ALUop)
            OP_ADD: fast_z = X + Y;
            OP_SUB: fast_z = X - Y;
            OP_AND: fast_z = X & Y;
            OP_OR:  fast_z = X | Y;
            OP_XOR: fast_z = X ^ Y;
            OP_NOT: fast_z = ~X;
            OP_SHL: fast_z = X << shamt;
            OP_SHR: fast_z = X >> shamt;
            OP_SRA: fast_z = WIDTH'($signed(X) >>> shamt);
            OP_SLT: fast_z = {{(WIDTH-1){1'b0}}, $signed(X) < $signed(Y)};
            OP_MUL: is_iter = 1'b1;
`ifdef ALU_SEQ_DIV_EN
            // Zero divisor resolves immediately instead of iterating.
            OP_DIVU: begin
                if (Y == '0) begin
                    fast_z   = '1;
                    fast_err = 1'b1;
                end else begin
                    is_iter = 1'b1;
                end
            end
            OP_REMU: begin
                if (Y == '0) begin
                    fast_z   = X;
                    fast_err = 1'b1;
                end else begin
                    is_iter = 1'b1;
                end
            end
`endif
            default: fast_err = 1'b1;
        endcase
    end

    assign mul_acc = acc_q + (b_q[0] ? a_q : '0);

`ifdef ALU_SEQ_DIV_EN
    logic [WIDTH:0]   rem_sh;
    logic [WIDTH:0]   rem_diff;
    logic             rem_ge;
    logic [WIDTH-1:0] div_q;
    logic [WIDTH-1:0] div_r;

    // Restoring step: a_q shifts the dividend out and the quotient in.
    assign rem_sh   = {acc_q, a_q[WIDTH-1]};
    assign rem_diff = rem_sh - {1'b0, b_q};
    assign rem_ge   = ~rem_diff[WIDTH];
    assign div_r    = rem_ge ? rem_diff[WIDTH-1:0] : rem_sh[WIDTH-1:0];
    assign div_q    = {a_q[WIDTH-2:0], rem_ge};
`endif

    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        a_d     = a_q;
        b_d     = b_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        z_d     = z_q;
        err_d   = err_q;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    op_d  = ALUop;
                    a_d   = X;
                    b_d   = Y;
                    acc_d = '0;
                    cnt_d = '0;
                    if (is_iter) begin
                        state_d = BUSY;
                    end else begin
                        state_d = DONE;
                        z_d     = fast_z;
                        err_d   = fast_err;
                    end
                end
            end
            BUSY: begin
                cnt_d = cnt_q + 1'b1;
                if (op_q == OP_MUL) begin
                    acc_d = mul_acc;
                    a_d   = {a_q[WIDTH-2:0], 1'b0};
                    b_d   = {1'b0, b_q[WIDTH-1:1]};
                end
`ifdef ALU_SEQ_DIV_EN
                else begin
                    acc_d = div_r;
                    a_d   = div_q;
                end
`endif
                if (cnt_q == CNT_LAST) begin
                    state_d = DONE;
                    cnt_d   = '0;
                    err_d   = 1'b0;
                    z_d     = mul_acc;
`ifdef ALU_SEQ_DIV_EN
                    if (op_q == OP_DIVU) z_d = div_q;
                    if (op_q == OP_REMU) z_d = div_r;
`endif
                end
            end
            DONE: begin
                if (out_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            op_q    <= '0;
            a_q     <= '0;
            b_q     <= '0;
            acc_q   <= '0;
            cnt_q   <= '0;
            z_q     <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            a_q     <= a_d;
            b_q     <= b_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            z_q     <= z_d;
            err_q   <= err_d;
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign z         = z_q;
    assign err       = err_q;

endmodule

// File: tb/tb_alu_seq.sv
// Directed bench for alu_seq: drives WIDTH=16 and WIDTH=32 instances,
// checking one width per pass against hand-computed vectors.
module tb_alu_seq;

    localparam logic [4:0] ADD  = 5'b00000;
    localparam logic [4:0] SUB  = 5'b00001;
    localparam logic [4:0] AND_ = 5'b00010;
    localparam logic [4:0] OR_  = 5'b00011;
    localparam logic [4:0] XOR_ = 5'b00100;
    localparam logic [4:0] NOT_ = 5'b00101;
    localparam logic [4:0] SHL  = 5'b00110;
    localparam logic [4:0] SHR  = 5'b00111;
    localparam logic [4:0] SRA  = 5'b01000;
    localparam logic [4:0] SLT  = 5'b01001;
    localparam logic [4:0] MUL  = 5'b01010;
    localparam logic [4:0] DIVU = 5'b01011;
    localparam logic [4:0] REMU = 5'b01100;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset, in_valid, out_ready;
    logic [4:0]  op;
    logic [31:0] xb, yb;
    logic        rdy16, vld16, err16;
    logic        rdy32, vld32, err32;
    logic [15:0] z16;
    logic [31:0] z32;
    logic        w32;
    logic [31:0] oz;
    logic        ov, ordy, oerr;
    int checks = 0;
    int errors = 0;

    alu_seq #(.WIDTH(16)) u16 (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(rdy16),
        .ALUop(op), .X(xb[15:0]), .Y(yb[15:0]), .out_valid(vld16),
        .out_ready(out_ready), .z(z16), .err(err16)
    );

    alu_seq #(.WIDTH(32)) u32 (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(rdy32),
        .ALUop(op), .X(xb), .Y(yb), .out_valid(vld32),
        .out_ready(out_ready), .z(z32), .err(err32)
    );

    always_comb begin
        oz   = w32 ? z32 : {16'h0, z16};
        ov   = w32 ? vld32 : vld16;
        ordy = w32 ? rdy32 : rdy16;
        oerr = w32 ? err32 : err16;
    end

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s w=%0d got=%0h exp=%0h", tag, w32 ? 32 : 16,
                   got, exp);
        end
    endtask

    task automatic run(input string tag, input logic [4:0] o,
                       input logic [31:0] x, input logic [31:0] y,
                       input logic [31:0] exz, input logic exe,
                       input int exlat);
        int   lat;
        logic busy_rdy;
        @(negedge clk);
        op = o; xb = x; yb = y; in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0; op = 5'h1F; xb = ~x; yb = ~y;
        lat = 1;
        busy_rdy = 1'b0;
        while (!ov && lat < 100) begin
            busy_rdy |= ordy;
            @(negedge clk);
            lat++;
        end
        chk({tag, " lat"}, 32'(lat), 32'(exlat));
        chk({tag, " z"}, oz, exz);
        chk({tag, " err"}, {31'b0, oerr}, {31'b0, exe});
        chk({tag, " busyrdy"}, {31'b0, busy_rdy | ordy}, 32'd0);
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        chk({tag, " rel"}, {30'b0, ov, ordy}, 32'd1);
        chk({tag, " hold"}, oz, exz);
    endtask

    task automatic run_all();
        logic [31:0] m, msb;
        int          W;
        logic        seen, moved;
        W   = w32 ? 32 : 16;
        m   = w32 ? 32'hFFFF_FFFF : 32'h0000_FFFF;
        msb = 32'(1) << (W - 1);

        reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        op = ADD; xb = '0; yb = '0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        chk("rst", {oz[29:0], oerr, ov}, 32'd0);
        chk("rst rdy", {31'b0, ordy}, 32'd1);

        run("add",  ADD,  m, 32'd1, 32'd0, 1'b0, 1);
        run("sub",  SUB,  32'd3, 32'd5, m - 32'd1, 1'b0, 1);
        run("and",  AND_, 32'h0FF0, 32'h3C3C, 32'h0C30, 1'b0, 1);
        run("or",   OR_,  32'h0FF0, 32'h3C3C, 32'h3FFC, 1'b0, 1);
        run("xor",  XOR_, 32'h0FF0, 32'h3C3C, 32'h33CC, 1'b0, 1);
        run("not",  NOT_, 32'h0FF0, 32'h0, m ^ 32'h0FF0, 1'b0, 1);
        run("shl",  SHL,  32'd1, 32'hFFE4, 32'h10, 1'b0, 1);
        run("shr",  SHR,  msb, w32 ? 32'hFFE3 : 32'hFFF3, msb >> 3,
            1'b0, 1);
        run("sra",  SRA,  msb, w32 ? 32'hFFE3 : 32'hFFF3, m ^ (m >> 4),
            1'b0, 1);
        run("slt1", SLT,  m, 32'd1, 32'd1, 1'b0, 1);
        run("slt0", SLT,  32'd1, m, 32'd0, 1'b0, 1);
        run("mul",  MUL,  32'h0123, 32'h0010, 32'h1230, 1'b0, W + 1);
        run("mulw", MUL,  m, m, 32'd1, 1'b0, W + 1);
`ifdef ALU_SEQ_DIV_EN
        run("divu",  DIVU, 32'd100, 32'd7, 32'd14, 1'b0, W + 1);
        run("remu",  REMU, 32'd100, 32'd7, 32'd2, 1'b0, W + 1);
        run("divu0", DIVU, 32'h1234, 32'd0, m, 1'b1, 1);
        run("remu0", REMU, 32'h1234, 32'd0, 32'h1234, 1'b1, 1);
`else
        run("divu",  DIVU, 32'd100, 32'd7, 32'd0, 1'b1, 1);
        run("remu",  REMU, 32'd100, 32'd7, 32'd0, 1'b1, 1);
`endif
        run("ill1f", 5'b11111, 32'h55, 32'h3, 32'd0, 1'b1, 1);
        run("ill0d", 5'b01101, 32'h55, 32'h3, 32'd0, 1'b1, 1);

        // Stall in DONE while a second request knocks.
        @(negedge clk);
        op = ADD; xb = 32'd2; yb = 32'd3; in_valid = 1'b1;
        @(negedge clk);
        xb = 32'd7; yb = 32'd7;
        moved = 1'b0;
        repeat (5) begin
            moved |= (oz != 32'd5) | !ov | ordy;
            @(negedge clk);
        end
        in_valid = 1'b0;
        chk("stall", {31'b0, moved | (oz != 32'd5) | !ov}, 32'd0);
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        chk("stall rel", {30'b0, ov, ordy}, 32'd1);
        chk("stall z", oz, 32'd5);
        @(negedge clk);
        chk("noqueue", {30'b0, ov, ordy}, 32'd1);

        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        chk("idle ordy", {30'b0, ov, ordy}, 32'd1);
        chk("idle z", oz, 32'd5);

        // Reset in the seventh cycle of a multiply.
        op = MUL; xb = 32'h0123; yb = 32'h0010; in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (6) @(negedge clk);
        chk("mid busy", {31'b0, ordy}, 32'd0);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk("mid rst", {oz[30:0], ov}, 32'd0);
        chk("mid rdy", {31'b0, ordy}, 32'd1);
        seen = 1'b0;
        repeat (W + 2) begin
            seen |= ov;
            @(negedge clk);
        end
        chk("mid none", {31'b0, seen | ov}, 32'd0);

        // Reset wins over a same-edge request.
        reset = 1'b1; in_valid = 1'b1; op = ADD; xb = 32'd1; yb = 32'd1;
        @(negedge clk);
        reset = 1'b0; in_valid = 1'b0;
        chk("rst prio", {oz[30:0], ov}, 32'd0);
        chk("rst prio rdy", {31'b0, ordy}, 32'd1);
    endtask

    initial begin
        w32 = 1'b0;
        run_all();
        w32 = 1'b1;
        run_all();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
